// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - 16-bit mode-0 SPI master: {rw, addr[6:0], wdata[7:0]}, MSB first.
// Optional miso capture into o_rd_data is enabled by defining SPI_CTRL_READBACK_EN.
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_rw,
  input  logic [6:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rd_data,
  output logic       o_sclk,
  output logic       o_cs_n,
  output logic       o_mosi,
  input  logic       i_miso
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP} state_t;

  localparam logic [7:0] LP_RELOAD = 8'(CLK_DIV - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [4:0]  r_bit;
  logic [15:0] r_shift;
  logic        r_sclk;
  logic        w_cnt_zero;
  logic        w_rise;
  logic        w_fall;
  logic        w_last;

  assign w_cnt_zero = (r_cnt == 8'd0);
  assign w_rise = w_cnt_zero && ((r_state == S_SETUP) ||
                                 (r_state == S_SHIFT && !r_sclk && r_bit != 5'd16));
  assign w_fall = w_cnt_zero && (r_state == S_SHIFT) && r_sclk;
  assign w_last = w_cnt_zero && (r_state == S_SHIFT) && !r_sclk && (r_bit == 5'd16);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start)   w_next = S_SETUP;
      S_SETUP: if (w_cnt_zero) w_next = S_SHIFT;
      S_SHIFT: if (w_last)    w_next = S_GAP;
      S_GAP:   if (w_cnt_zero) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state != S_IDLE);
    o_cs_n = !((r_state == S_SETUP) || (r_state == S_SHIFT));
    o_mosi = ((r_state == S_SETUP) || (r_state == S_SHIFT)) ? r_shift[15] : 1'b0;
    o_sclk = r_sclk;
    o_done = (r_state == S_GAP) && w_cnt_zero;
  end

  // Half-period counter reloads at zero in every active state, so it never wraps.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= 8'd0;
      r_bit   <= 5'd0;
      r_shift <= 16'd0;
      r_sclk  <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        if (i_start) begin
          r_shift <= {i_rw, i_addr, i_wdata};
          r_cnt   <= LP_RELOAD;
          r_bit   <= 5'd0;
        end
      end else begin
        r_cnt <= w_cnt_zero ? LP_RELOAD : r_cnt - 8'd1;
      end
      if (w_rise) begin
        r_sclk <= 1'b1;
        r_bit  <= r_bit + 5'd1;
      end
      if (w_fall) begin
        r_sclk  <= 1'b0;
        r_shift <= {r_shift[14:0], 1'b0};
      end
    end
  end

`ifdef SPI_CTRL_READBACK_EN
  logic [7:0] r_cap;
  logic [7:0] r_rd_data;

  // miso is sampled on the edge that raises sclk; the slave updates it on the falling edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cap     <= 8'h00;
      r_rd_data <= 8'h00;
    end else begin
      if (w_rise) begin
        r_cap <= {r_cap[6:0], i_miso};
      end
      if (w_last) begin
        r_rd_data <= r_cap;
      end
    end
  end

  assign o_rd_data = r_rd_data;
`else
  logic w_unused_miso;
  assign w_unused_miso = i_miso;
  assign o_rd_data     = 8'h00;
`endif

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter CLK_DIV, default 4, meaning SCLK half-period in clk cycles; legal range 1..255.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  transaction request, sampled each clk.
REQ-005 rw  input  1  1 = write frame, 0 = read frame; becomes frame bit 15.
REQ-006 addr  input  7  register address; frame bits 14:8.
REQ-007 wdata  input  8  write data; frame bits 7:0.
REQ-008 busy  output  1  high while a transaction is in progress.
REQ-009 done  output  1  one-cycle pulse at transaction end.
REQ-010 rd_data  output  8  last 8 bits captured from miso.
REQ-011 sclk  output  1  SPI clock, mode 0, idle low.
REQ-012 cs_n  output  1  chip select, active low.
REQ-013 mosi  output  1  serial data out, MSB first.
REQ-014 miso  input  1  serial data in.

Function
REQ-015 The block SHALL be a controller for 16-bit SPI frames {rw, addr[6:0], wdata[7:0]}, MSB first, mode 0.
REQ-016 States SHALL be IDLE, SETUP, SHIFT, GAP; only IDLE accepts start.
REQ-017 In IDLE with start=1: latch {rw,addr,wdata} into a 16-bit shift register, enter SETUP, and set busy=1, cs_n=0, mosi=frame[15] on the next clk.
REQ-018 start while busy=1 SHALL be ignored; latched frame SHALL NOT change mid-transaction.
REQ-019 SETUP SHALL last CLK_DIV cycles with sclk=0, then enter SHIFT.
REQ-020 SHIFT SHALL emit 16 SCLK periods, each CLK_DIV cycles high then CLK_DIV cycles low.
REQ-021 mosi SHALL change only when sclk falls, presenting the next bit; mosi is stable for the entire high phase.
REQ-022 A 5-bit bit counter SHALL count rising SCLK edges; after the 16th low phase, cs_n=1, sclk=0, mosi=0, enter GAP.
REQ-023 GAP SHALL last CLK_DIV cycles with cs_n=1; in its final cycle done=1; next cycle busy=0, state IDLE.
REQ-024 cs_n low duration SHALL be exactly 33*CLK_DIV cycles; busy high duration SHALL be exactly 34*CLK_DIV cycles.
REQ-025 start asserted in the cycle after done (busy=0) SHALL be accepted; back-to-back frames are separated by at least CLK_DIV cycles of cs_n=1.
REQ-026 The half-period counter SHALL be 8 bits, reload to CLK_DIV-1, count down, and never wrap past zero.
REQ-027 Read frames (rw=0) SHALL shift out exactly like writes; wdata bits are still driven.

Reset
REQ-028 While rst=1: state IDLE, busy=0, done=0, cs_n=1, sclk=0, mosi=0, rd_data=8'h00, counters and shift register cleared.
REQ-029 Reset asserted mid-transaction SHALL abort immediately with no done pulse; cs_n rises asynchronously.
REQ-030 After rst deasserts, the first start SHALL be accepted on the first clk edge.

Configuration
REQ-031 Macro SPI_CTRL_READBACK_EN SHALL gate miso capture.
REQ-032 With SPI_CTRL_READBACK_EN defined: sample miso in the clk cycle sclk rises, shift into an 8-bit register, and load rd_data on the done cycle (last 8 sampled bits, MSB first) for every frame.
REQ-033 Without SPI_CTRL_READBACK_EN: miso ignored, rd_data constant 8'h00, no capture register.

Verification
REQ-034 CLK_DIV=4, start with rw=1, addr=7'h02, wdata=8'hA5 -> mosi samples at sclk rises = 16'h82A5; cs_n low 132 cycles; done one pulse after 136 busy cycles.
REQ-035 start pulsed again 10 cycles into a frame with addr=7'h04 -> ignored; only frame 16'h82A5 emitted.
REQ-036 READBACK_EN, rw=0, addr=7'h01, miso model drives 8'h3C on bits 7:0 -> rd_data=8'h3C on done cycle.
REQ-037 rst asserted after 5 sclk rises -> cs_n=1, sclk=0 same cycle; no done; next start emits full 16-bit frame.
REQ-038 CLK_DIV=1, two frames with start held high -> sclk toggles every cycle; cs_n high exactly 2 cycles between frames (GAP + IDLE).
REQ-039 Without READBACK_EN, miso toggling every cycle -> rd_data stays 8'h00.
